// File: rtl/timer_pkg.sv
// Shared types and constants for the APB timer: FSM state encoding, the default
// divisor clamp and the register map offsets.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } timer_state_e;

  localparam int DIV_MAX = 8;

  localparam logic [7:0] TCR   = 8'h00;
  localparam logic [7:0] TDR0  = 8'h04;
  localparam logic [7:0] TDR1  = 8'h08;
  localparam logic [7:0] TCMP0 = 8'h0C;
  localparam logic [7:0] TCMP1 = 8'h10;
  localparam logic [7:0] TIER  = 8'h14;
  localparam logic [7:0] TISR  = 8'h18;
  localparam logic [7:0] THCSR = 8'h1C;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer counter: divides the RUN cycles by 2^N and emits a
// one-cycle tick at the end of each period. Phase is frozen while held.
module timer_prescaler #(
  parameter int DIV_W   = 4,
  parameter int DIV_MAX = timer_pkg::DIV_MAX,
  parameter int PDIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             hold,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);
  import timer_pkg::*;

  logic [PDIV_W-1:0] div_cnt;
  logic [PDIV_W-1:0] div_mask;
  logic [PDIV_W:0]   div_span;
  logic [DIV_W-1:0]  n_eff;
  logic              div_en_q;
  logic [DIV_W-1:0]  div_val_q;
  logic              cfg_changed;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    n_eff = '0;
    if (div_en) begin
      n_eff = (div_val > DIV_W'(DIV_MAX)) ? DIV_W'(DIV_MAX) : div_val;
    end
  end

  // The extra span bit lets N == PDIV_W produce an all-ones mask.
  assign div_span    = (PDIV_W+1)'(1) << n_eff;
  assign div_mask    = PDIV_W'(div_span - (PDIV_W+1)'(1));
  assign cfg_changed = (div_en != div_en_q) || (div_val != div_val_q);
  assign tick        = run && (div_cnt == div_mask);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      div_en_q  <= 1'b0;
      div_val_q <= '0;
    end else begin
      div_en_q  <= div_en;
      div_val_q <= div_val;
      if (cfg_changed) begin
        div_cnt <= '0;
      end else if (run) begin
        div_cnt <= tick ? '0 : div_cnt + PDIV_W'(1);
      end else if (!hold) begin
        div_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller for the 64-bit timer counter: IDLE/RUN/HALT FSM,
// prescaled increment strobe, clear-on-disable pulse and compare interrupt.
module timer_ctrl #(
  parameter int DIV_W   = 4,
  parameter int DIV_MAX = timer_pkg::DIV_MAX,
  parameter int PDIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             dbg_mode,
  input  logic             halt_req,
  input  logic             int_en,
  input  logic             int_st_clr,
  input  logic [63:0]      cnt,
  input  logic [63:0]      cmp,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             halt_ack,
  output logic             int_st,
  output logic             tim_int
);
  import timer_pkg::*;

  timer_state_e state, state_next;
  logic         halt;
  logic         timer_en_q;
  logic         tick;

  assign halt = halt_req & dbg_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Halt wins over every other transition.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (halt) state_next = HALT;
               else if (timer_en) state_next = RUN;
      RUN:     if (halt) state_next = HALT;
               else if (!timer_en) state_next = IDLE;
      HALT:    if (!halt) state_next = timer_en ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  timer_prescaler #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX),
    .PDIV_W  (PDIV_W)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == RUN),
    .hold    (state == HALT),
    .div_en  (div_en),
    .div_val (div_val),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_en_q <= 1'b0;
      cnt_clr    <= 1'b0;
      int_st     <= 1'b0;
    end else begin
      timer_en_q <= timer_en;
      cnt_clr    <= timer_en_q & ~timer_en;
      int_st     <= (cnt == cmp) | (int_st & ~int_st_clr);
    end
  end

  assign cnt_en   = tick & ~cnt_clr;
  assign halt_ack = (state == HALT);
  assign tim_int  = int_st & int_en;

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the 64-bit timer counter in the APB timer. It turns the TCR control bits (enable, prescaler enable, divisor) into the counter's `cnt_en` strobe and clears the counter when the timer is disabled. It also runs the debug-halt handshake and raises the compare-match interrupt from the counter value. It sits between the APB register block and the counter.

## Interface
- `DIV_W`, default 4: width of the divisor field.
- `DIV_MAX`, default 8: largest legal divisor exponent; larger values clamp to `DIV_MAX`.
- `PDIV_W`, default 8: width of the prescaler counter; must be at least `DIV_MAX`.
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `timer_en`, input, 1: TCR timer enable.
- `div_en`, input, 1: TCR prescaler enable.
- `div_val`, input, `DIV_W`: TCR divisor exponent N; the counter increments every 2^N cycles.
- `dbg_mode`, input, 1: CPU debug mode indication.
- `halt_req`, input, 1: THCSR halt request (level).
- `int_en`, input, 1: TIER interrupt enable.
- `int_st_clr`, input, 1: one-cycle write-1-to-clear pulse for TISR.
- `cnt`, input, 64: current counter value.
- `cmp`, input, 64: compare value {TCMP1, TCMP0}.
- `cnt_en`, output, 1: counter increment strobe.
- `cnt_clr`, output, 1: one-cycle pulse that clears the counter to 0.
- `halt_ack`, output, 1: THCSR halt acknowledge.
- `int_st`, output, 1: TISR interrupt status (sticky).
- `tim_int`, output, 1: interrupt line, equal to `int_st & int_en`.

## Operation
- The FSM has three states: IDLE, RUN and HALT. Reset puts it in IDLE.
- IDLE → RUN when `timer_en` is high and `halt_req & dbg_mode` is low.
- IDLE or RUN → HALT when `halt_req & dbg_mode` is high. Halt takes priority over every other transition.
- RUN → IDLE when `timer_en` is low.
- HALT → RUN when `halt_req & dbg_mode` is low and `timer_en` is high. HALT → IDLE when `halt_req & dbg_mode` is low and `timer_en` is low.
- Prescaler:
  - Effective N is 0 when `div_en` is 0; otherwise `min(div_val, DIV_MAX)`.
  - In RUN, `div_cnt` counts 0 to 2^N−1 and wraps.
  - `cnt_en = (state==RUN) && (div_cnt == 2^N−1)`. With N=0, `cnt_en` is high every RUN cycle.
  - `div_cnt` holds its value in HALT.
  - `div_cnt` resets to 0 in IDLE, and on the cycle after any change of `div_en` or `div_val`.
- `cnt_clr` pulses for one cycle on a registered falling edge of `timer_en`, in any state. The counter does not increment while `cnt_clr` is high.
- Interrupt status:
  - `int_st` sets when `cnt == cmp` at a rising edge, in any state.
  - `int_st` clears on `int_st_clr`.
  - If set and clear occur in the same cycle, set wins.
- Register writes to the counter are outside this block. `cnt_en` is not gated by them.

## Timing
- Reset values:
  - state = IDLE.
  - `div_cnt` = 0.
  - `cnt_en`, `cnt_clr`, `halt_ack`, `int_st` and `tim_int` are all 0.
- `timer_en` rising in cycle 0 puts the FSM in RUN from cycle 1. With N=0, `cnt_en` is high in cycle 1 and `cnt` first increments at the end of cycle 1.
- For N>0, the first `cnt_en` occurs in cycle 2^N. After that, `cnt_en` is exactly one cycle high every 2^N cycles.
- `halt_req` plus `dbg_mode` high in cycle k:
  - `halt_ack` = 1 and `cnt_en` = 0 from cycle k+1.
  - After the request drops, `halt_ack` = 0 one cycle later.
  - The prescaler phase is preserved across the halt.
- `timer_en` falling in cycle k: `cnt_clr` = 1 in cycle k+1 only, and `cnt_en` = 0 from cycle k+1.
- `cnt == cmp` in cycle k: `int_st` = 1 from cycle k+1.
- `tim_int` is combinational from `int_st` and `int_en`.
- Asserting `rst_n` mid-count or mid-halt returns all outputs to their reset values immediately, asynchronously.

## Structure
- Package `timer_pkg` holds:
  - the state typedef `timer_state_e` (IDLE, RUN, HALT);
  - `DIV_MAX`;
  - register offset constants TCR, TDR0, TDR1, TCMP0, TCMP1, TIER, TISR and THCSR.
- Sub-module `timer_prescaler` contains `div_cnt`, the clamp logic, the change-detect reset and the `cnt_en` tick. Its ports are `run`, `hold`, `div_en`, `div_val` and `tick`.
- The FSM, `cnt_clr` edge detect and interrupt logic stay in `timer_ctrl`.

## Test plan
- **Default enable:** reset, then `timer_en`=1 with `div_en`=0 → `cnt_en` high every cycle from cycle 1; `cnt` = 10 after 10 cycles.
- **Prescaler:** `div_en`=1, `div_val`=3 → `cnt_en` one cycle in every 8. `div_val`=12 → clamped, one cycle in every 256.
- **Debug halt:** `dbg_mode`=1 and `halt_req`=1 mid-period with `div_cnt`=5, N=3 → `halt_ack`=1 next cycle and `cnt` frozen. On release, the first `cnt_en` comes 3 cycles later. `halt_req`=1 with `dbg_mode`=0 → no halt.
- **Disable and restart:** `timer_en` 1→0 → single `cnt_clr` pulse and `cnt`=0. Re-enable → counting restarts from 0 with `div_cnt`=0.
- **Interrupt:** `cmp`=0x5, `int_en`=1 → `int_st` and `tim_int` go high the cycle after `cnt`=5. `int_st_clr` → 0. `int_st_clr` in the same cycle as a match → stays 1. `int_en`=0 → `tim_int`=0 while `int_st`=1.
- **Reset mid-halt:** assert `rst_n`=0 during HALT → `halt_ack`=0 immediately and state is IDLE after release.
